// File: rtl/hdc_stream_classifier.sv
`default_nettype none
// hdc_stream_classifier: streaming hyperdimensional text classifier (bundle, threshold, Hamming argmin).
// Optional feature macro HDC_DIST_OUT_EN adds the best_dist output. Rev 1.0
module hdc_stream_classifier #(
   parameter int DIM       = 1024,
   parameter int CHUNK     = 32,
   parameter int NUM_CLASS = 2,
   parameter int CNT_W     = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [7:0]                        in_char,
   input  logic                              in_last,
   input  logic                              cfg_we,
   input  logic                              cfg_sel,
   input  logic [$clog2(37*(DIM/CHUNK))-1:0] cfg_addr,
   input  logic [CHUNK-1:0]                  cfg_wdata,
   output logic                              out_valid,
   output logic [$clog2(NUM_CLASS)-1:0]      out_class,
   output logic                              out_tie
`ifdef HDC_DIST_OUT_EN
   ,output logic [$clog2(DIM+1)-1:0]         best_dist
`endif
);

   localparam int NUM_SYM = 37;
   localparam int NW      = DIM / CHUNK;
   localparam int AW      = $clog2(NUM_SYM * NW);
   localparam int PAW     = $clog2(NUM_CLASS * NW);
   localparam int KW      = (NW > 1) ? $clog2(NW) : 1;
   localparam int CLW     = $clog2(NUM_CLASS);
   localparam int DW      = $clog2(DIM + 1);
   localparam int PW      = $clog2(CHUNK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [KW-1:0]    K_LAST  = KW'(NW - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_COMPARE, S_RESULT} state_t;

   state_t             r_state;
   logic [5:0]         r_sym;
   logic [KW-1:0]      r_k;
   logic               r_first;
   logic               r_last;
   logic [CNT_W-1:0]   r_len;
   logic [CNT_W-1:0]   r_cnt       [NW][CHUNK];
   logic [DW-1:0]      r_dist      [NUM_CLASS];
   logic [CHUNK-1:0]   r_item_mem  [NUM_SYM*NW];
   logic [CHUNK-1:0]   r_proto_mem [NUM_CLASS*NW];

   logic [AW-1:0]      w_item_addr;
   logic [CHUNK-1:0]   w_item_word;
   logic [CHUNK-1:0]   w_hv;
   logic [CHUNK-1:0]   w_x;
   logic [PAW-1:0]     w_paddr;
   logic [PW-1:0]      w_pop       [NUM_CLASS];
   logic [CLW-1:0]     w_best;
   logic [DW-1:0]      w_min;
   logic               w_tie;

   function automatic logic [5:0] f_sym(input logic [7:0] ch);
      if (ch >= 8'd65 && ch <= 8'd90)
         f_sym = 6'(ch - 8'd54);
      else if (ch >= 8'd97 && ch <= 8'd122)
         f_sym = 6'(ch - 8'd86);
      else if (ch >= 8'd48 && ch <= 8'd57)
         f_sym = 6'(ch - 8'd47);
      else
         f_sym = 6'd0;
   endfunction

   assign w_item_addr = AW'(r_sym) * AW'(NW) + AW'(r_k);
   assign w_item_word = r_item_mem[w_item_addr];

   // A tie (2*cnt == len) thresholds to 0.
   always_comb begin
      for (int b = 0; b < CHUNK; b++)
         w_hv[b] = {r_cnt[r_k][b], 1'b0} > {1'b0, r_len};
   end

   always_comb begin
      w_x     = '0;
      w_paddr = '0;
      for (int c = 0; c < NUM_CLASS; c++) begin
         w_paddr  = PAW'(c) * PAW'(NW) + PAW'(r_k);
         w_x      = w_hv ^ r_proto_mem[w_paddr];
         w_pop[c] = '0;
         for (int b = 0; b < CHUNK; b++)
            w_pop[c] = w_pop[c] + PW'(w_x[b]);
      end
   end

   always_comb begin
      w_best = '0;
      w_min  = r_dist[0];
      w_tie  = 1'b0;
      for (int c = 1; c < NUM_CLASS; c++) begin
         if (r_dist[c] < w_min) begin
            w_min  = r_dist[c];
            w_best = CLW'(c);
         end
      end
      for (int c = 0; c < NUM_CLASS; c++) begin
         if (r_dist[c] == w_min && CLW'(c) != w_best)
            w_tie = 1'b1;
      end
   end

   // Memories are deliberately outside the reset domain so contents survive rst.
   always_ff @(posedge clk) begin
      if (cfg_we && r_state == S_IDLE) begin
         if (!cfg_sel) begin
            if (cfg_addr < AW'(NUM_SYM * NW))
               r_item_mem[cfg_addr] <= cfg_wdata;
         end else if (cfg_addr < AW'(NUM_CLASS * NW)) begin
            r_proto_mem[cfg_addr[PAW-1:0]] <= cfg_wdata;
         end
      end
   end

   // First character overwrites the counters, which avoids a separate clear pass.
   always_ff @(posedge clk) begin
      if (r_state == S_ACCUM) begin
         for (int b = 0; b < CHUNK; b++) begin
            if (r_first)
               r_cnt[r_k][b] <= CNT_W'(w_item_word[b]);
            else if (w_item_word[b] && r_cnt[r_k][b] != CNT_MAX)
               r_cnt[r_k][b] <= r_cnt[r_k][b] + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_class <= '0;
         out_tie   <= 1'b0;
         r_k       <= '0;
         r_len     <= '0;
         r_first   <= 1'b1;
         r_sym     <= '0;
         r_last    <= 1'b0;
         for (int c = 0; c < NUM_CLASS; c++)
            r_dist[c] <= '0;
`ifdef HDC_DIST_OUT_EN
         best_dist <= '0;
`endif
      end else begin
         out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sym    <= f_sym(in_char);
                  r_last   <= in_last;
                  r_k      <= '0;
                  in_ready <= 1'b0;
                  r_len    <= r_first ? CNT_ONE :
                              ((r_len == CNT_MAX) ? r_len : r_len + CNT_ONE);
                  r_state  <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (r_k == K_LAST) begin
                  r_k     <= '0;
                  r_first <= 1'b0;
                  if (r_last) begin
                     for (int c = 0; c < NUM_CLASS; c++)
                        r_dist[c] <= '0;
                     r_state <= S_COMPARE;
                  end else begin
                     in_ready <= 1'b1;
                     r_state  <= S_IDLE;
                  end
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            S_COMPARE: begin
               for (int c = 0; c < NUM_CLASS; c++)
                  r_dist[c] <= r_dist[c] + DW'(w_pop[c]);
               if (r_k == K_LAST) begin
                  r_k     <= '0;
                  r_state <= S_RESULT;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            S_RESULT: begin
               out_valid <= 1'b1;
               out_class <= w_best;
               out_tie   <= w_tie;
`ifdef HDC_DIST_OUT_EN
               best_dist <= w_min;
`endif
               r_first   <= 1'b1;
               in_ready  <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hdc_stream_classifier.sv
`default_nettype none
// tb_hdc_stream_classifier: directed self-checking bench, DIM=64 CHUNK=32 NUM_CLASS=2.
`timescale 1ns/1ps
module tb_hdc_stream_classifier;

   localparam int DIM = 64, CHUNK = 32, NUM_CLASS = 2, CNT_W = 8, AW = 7;
   localparam logic [CHUNK-1:0] ONES = {CHUNK{1'b1}};
   localparam logic [7:0] CH_UA = 8'h41, CH_LA = 8'h61, CH_PCT = 8'h25;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, in_last;
   logic [7:0]       in_char;
   logic             cfg_we, cfg_sel;
   logic [AW-1:0]    cfg_addr;
   logic [CHUNK-1:0] cfg_wdata;
   logic             out_valid, out_tie;
   logic [0:0]       out_class;
`ifdef HDC_DIST_OUT_EN
   logic [6:0]       best_dist;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hdc_stream_classifier #(.DIM(DIM), .CHUNK(CHUNK), .NUM_CLASS(NUM_CLASS), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .out_valid(out_valid), .out_class(out_class), .out_tie(out_tie)
`ifdef HDC_DIST_OUT_EN
      ,.best_dist(best_dist)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input logic sel, input logic [AW-1:0] addr, input logic [CHUNK-1:0] data);
      cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Entered and left at a falling edge; returns on the falling edge just after acceptance.
   task automatic send_char(input logic [7:0] ch, input logic last);
      int w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check("ready_timeout", 0, 1);
      in_valid = 1'b1; in_char = ch; in_last = last;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // lat counts rising edges since acceptance of the final character.
   task automatic wait_result(input int start, output int lat, output int cls, output int tie);
      lat = start;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) check("result_timeout", 0, 1);
      cls = int'(out_class);
      tie = int'(out_tie);
      @(negedge clk);
      check("valid_pulse", {31'd0, out_valid}, 0);
   endtask

   task automatic run_msg(input logic [7:0] c1, input int n1, input logic [7:0] c2, input int n2,
                          output int lat, output int cls, output int tie);
      int total = n1 + n2;
      for (int i = 0; i < total; i++)
         send_char((i < n1) ? c1 : c2, (i == total - 1));
      wait_result(0, lat, cls, tie);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, cls, tie, bad;
      rst = 1'b1; in_valid = 1'b0; in_char = '0; in_last = 1'b0;
      cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 1);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_class", {31'd0, out_class}, 0);
      check("rst_out_tie", {31'd0, out_tie}, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int a = 0; a < 74; a++)
         cfg_write(1'b0, AW'(a), (a / 2 == 11) ? ONES : '0);
      cfg_write(1'b1, 7'd0, ONES);
      cfg_write(1'b1, 7'd1, ONES);
      cfg_write(1'b1, 7'd2, '0);
      cfg_write(1'b1, 7'd3, '0);

      // "A": hv all ones -> proto0 distance 0
      run_msg(CH_UA, 1, CH_UA, 0, lat, cls, tie);
      check("A_latency", lat, 5);
      check("A_class", cls, 0);
      check("A_tie", tie, 0);
`ifdef HDC_DIST_OUT_EN
      check("A_best_dist", {25'd0, best_dist}, 0);
`endif

      // "a%": cnt=1, len=2 -> hv all zeros -> proto1
      send_char(CH_LA, 1'b0);
      check("a_ready_k0", {31'd0, in_ready}, 0);
      @(negedge clk);
      check("a_ready_k1", {31'd0, in_ready}, 0);
      @(negedge clk);
      check("a_ready_back", {31'd0, in_ready}, 1);
      send_char(CH_PCT, 1'b1);
      wait_result(0, lat, cls, tie);
      check("apct_class", cls, 1);
      check("apct_tie", tie, 0);
`ifdef HDC_DIST_OUT_EN
      check("apct_best_dist", {25'd0, best_dist}, 0);
`endif
      repeat (3) @(negedge clk);
      check("apct_hold_class", {31'd0, out_class}, 1);

      run_msg(CH_LA, 1, CH_LA, 0, lat, cls, tie);
      check("a_class", cls, 0);

      // Reset during ACCUM word 1, after two prior characters built up len.
      send_char(CH_PCT, 1'b0);
      send_char(CH_PCT, 1'b0);
      send_char(CH_PCT, 1'b0);
      @(negedge clk);
      check("midrst_ready_before", {31'd0, in_ready}, 0);
      rst = 1'b1;
      #1;
      check("midrst_ready_async", {31'd0, in_ready}, 1);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      check("midrst_no_valid", bad, 0);
      run_msg(CH_UA, 1, CH_UA, 0, lat, cls, tie);
      check("midrst_A_class", cls, 0);

      // Prototype writes while in COMPARE must be dropped.
      send_char(CH_UA, 1'b1);
      repeat (2) @(negedge clk);
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 7'd0; cfg_wdata = '0;
      @(negedge clk);
      cfg_addr = 7'd1;
      @(negedge clk);
      cfg_we = 1'b0;
      wait_result(4, lat, cls, tie);
      check("cmpwr_latency", lat, 5);
      check("cmpwr_class", cls, 0);
      check("cmpwr_tie", tie, 0);

      // Out-of-range prototype addresses must be dropped.
      cfg_write(1'b1, 7'd4, '0);
      cfg_write(1'b1, 7'd5, '0);
      run_msg(CH_UA, 1, CH_UA, 0, lat, cls, tie);
      check("after_wr_class", cls, 0);
      check("after_wr_tie", tie, 0);

      // Equal prototypes -> lowest index with tie flag.
      cfg_write(1'b1, 7'd0, '0);
      cfg_write(1'b1, 7'd1, '0);
      run_msg(CH_UA, 1, CH_UA, 0, lat, cls, tie);
      check("tie_class", cls, 0);
      check("tie_flag", tie, 1);
`ifdef HDC_DIST_OUT_EN
      check("tie_best_dist", {25'd0, best_dist}, 64);
`endif
      cfg_write(1'b1, 7'd0, ONES);
      cfg_write(1'b1, 7'd1, ONES);

      // Saturation: cnt and len clamp at 255.
      run_msg(CH_LA, 300, CH_LA, 0, lat, cls, tie);
      check("sat300_class", cls, 0);
      check("sat300_tie", tie, 0);
      run_msg(CH_LA, 260, CH_PCT, 40, lat, cls, tie);
      check("sat_cnt_class", cls, 0);
      run_msg(CH_LA, 100, CH_PCT, 200, lat, cls, tie);
      check("sat_len_class", cls, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
